decode_stage_pipelined: RTL and testbench



---
 rtl/decode_stage_pipelined.sv | 176 +++++++++++++++++
 tb/tb_decode_stage_pipelined.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipelined.sv
// RV32/RV64 decode stage with a registered ID/EX output, register file with write-back bypass,
// load-use stall, flush and branch resolution. Define DECODE_TRACE_EN to print each accepted instruction.
module decode_stage_pipelined #(
   parameter int XLEN      = 32,
   parameter int REG_COUNT = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [31:0]     i_inst,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_flush,
   input  logic            i_ready,
   output logic            o_valid,
   input  logic            i_wb_en,
   input  logic [4:0]      i_wb_rd_num,
   input  logic [XLEN-1:0] i_wb_val,
   input  logic            i_ex_load,
   input  logic [4:0]      i_ex_rd_num,
   output logic [XLEN-1:0] rs_1,
   output logic [XLEN-1:0] rs_2,
   output logic [4:0]      rd_num,
   output logic [6:0]      opcode,
   output logic [2:0]      func_3,
   output logic [6:0]      func_7,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] pc,
   output logic            b_taken,
   output logic [XLEN-1:0] b_pc
);
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;

   logic [XLEN-1:0] regs_q [1:REG_COUNT-1];

   logic [6:0]      op_w;
   logic [2:0]      f3_w;
   logic [4:0]      rs1_idx, rs2_idx;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm_x;
   logic            uses_rs1, uses_rs2, hazard, accept, br_cond;
   logic [XLEN-1:0] jalr_sum;

   logic            valid_q;
   logic [XLEN-1:0] rs1_q, rs2_q, imm_q, pc_q;
   logic [4:0]      rd_q;
   logic [6:0]      op_q, f7_q;
   logic [2:0]      f3_q;

   assign op_w    = i_inst[6:0];
   assign f3_w    = i_inst[14:12];
   assign rs1_idx = i_inst[19:15];
   assign rs2_idx = i_inst[24:20];

   // Out-of-range and x0 reads fall through the loop and stay 0; a same-cycle write wins.
   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      for (int i = 1; i < REG_COUNT; i++) begin
         if (rs1_idx == 5'(i))
            rs1_val = (i_wb_en && i_wb_rd_num == 5'(i)) ? i_wb_val : regs_q[i];
         if (rs2_idx == 5'(i))
            rs2_val = (i_wb_en && i_wb_rd_num == 5'(i)) ? i_wb_val : regs_q[i];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 1; i < REG_COUNT; i++) regs_q[i] <= '0;
      end else if (i_wb_en) begin
         for (int i = 1; i < REG_COUNT; i++)
            if (i_wb_rd_num == 5'(i)) regs_q[i] <= i_wb_val;
      end
   end

   always_comb begin
      imm32 = '0;
      case (op_w)
         OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
         OP_STORE:                 imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
         OP_BR:                    imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                                            i_inst[30:25], i_inst[11:8], 1'b0};
         OP_LUI, OP_AUIPC:         imm32 = {i_inst[31:12], 12'b0};
         OP_JAL:                   imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                                            i_inst[20], i_inst[30:21], 1'b0};
         default:                  imm32 = '0;
      endcase
      imm_x        = {XLEN{imm32[31]}};
      imm_x[31:0]  = imm32;
   end

   assign uses_rs1 = !(op_w == OP_LUI || op_w == OP_AUIPC || op_w == OP_JAL);
   assign uses_rs2 = (op_w == OP_BR || op_w == OP_STORE || op_w == OP_REG);
   assign hazard   = i_ex_load && (i_ex_rd_num != 5'd0) &&
                     ((uses_rs1 && rs1_idx == i_ex_rd_num) || (uses_rs2 && rs2_idx == i_ex_rd_num));
   assign o_ready  = (!valid_q || i_ready) && !hazard;
   assign accept   = i_valid && o_ready && !i_flush;

   always_comb begin
      case (f3_w)
         3'b000:  br_cond = (rs1_val == rs2_val);
         3'b001:  br_cond = (rs1_val != rs2_val);
         3'b100:  br_cond = ($signed(rs1_val) <  $signed(rs2_val));
         3'b101:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
         3'b110:  br_cond = (rs1_val <  rs2_val);
         3'b111:  br_cond = (rs1_val >= rs2_val);
         default: br_cond = 1'b0;
      endcase
   end

   assign jalr_sum = rs1_val + imm_x;
   assign b_taken  = accept && (op_w == OP_JAL || op_w == OP_JALR || (op_w == OP_BR && br_cond));
   assign b_pc     = !b_taken          ? '0 :
                     (op_w == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} :
                                         i_pc + imm_x;

   // Flush beats accept; a non-accepting cycle with downstream ready drains to a bubble.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         valid_q <= 1'b0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
         rd_q    <= '0;
         op_q    <= '0;
         f3_q    <= '0;
         f7_q    <= '0;
      end else if (i_flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         rs1_q   <= rs1_val;
         rs2_q   <= rs2_val;
         imm_q   <= imm_x;
         pc_q    <= i_pc;
         rd_q    <= i_inst[11:7];
         op_q    <= op_w;
         f3_q    <= f3_w;
         f7_q    <= i_inst[31:25];
      end else if (i_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign o_valid = valid_q;
   assign rs_1    = rs1_q;
   assign rs_2    = rs2_q;
   assign imm     = imm_q;
   assign pc      = pc_q;
   assign rd_num  = rd_q;
   assign opcode  = op_q;
   assign func_3  = f3_q;
   assign func_7  = f7_q;

`ifdef DECODE_TRACE_EN
   always_ff @(posedge i_clk) begin
      if (i_rst && accept) begin
         $display("---begin decode---");
         $display("pc=%h inst=%h rd_num=%h rs_1=%h rs_2=%h imm=%h b_taken=%h b_pc=%h",
                  i_pc, i_inst, i_inst[11:7], rs1_val, rs2_val, imm_x, b_taken, b_pc);
         $display("---end decode---");
      end
   end
`else
`endif
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Bench for decode_stage_pipelined: directed scenarios plus random traffic against a reference model.
module tb_decode_stage_pipelined;
   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        valid, flush, rdy, wb_en, ex_load;
   logic [31:0] inst, pc_in, wb_val;
   logic [4:0]  wb_rd, ex_rd;

   logic        o_ready, o_valid, b_taken;
   logic [31:0] rs_1, rs_2, imm, pc, b_pc;
   logic [4:0]  rd_num;
   logic [6:0]  opcode, func_7;
   logic [2:0]  func_3;

   logic        u_ready, u_valid, u_taken;
   logic [31:0] u_rs_1, u_rs_2, u_imm, u_pc, u_bpc;
   logic [4:0]  u_rd;
   logic [6:0]  u_op, u_f7;
   logic [2:0]  u_f3;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] m_regs [32];
   logic        m_valid;
   logic [31:0] m_rs1, m_rs2, m_imm, m_pc;
   logic [4:0]  m_rd;
   logic [6:0]  m_op, m_f7;
   logic [2:0]  m_f3;
   logic        obs_ready, obs_tk;
   logic [31:0] obs_bpc;

   always #5 i_clk = ~i_clk;

   decode_stage_pipelined #(.XLEN(32), .REG_COUNT(32)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(valid), .o_ready(o_ready), .i_inst(inst),
      .i_pc(pc_in), .i_flush(flush), .i_ready(rdy), .o_valid(o_valid), .i_wb_en(wb_en),
      .i_wb_rd_num(wb_rd), .i_wb_val(wb_val), .i_ex_load(ex_load), .i_ex_rd_num(ex_rd),
      .rs_1(rs_1), .rs_2(rs_2), .rd_num(rd_num), .opcode(opcode), .func_3(func_3),
      .func_7(func_7), .imm(imm), .pc(pc), .b_taken(b_taken), .b_pc(b_pc));

   decode_stage_pipelined #(.XLEN(32), .REG_COUNT(16)) dut16 (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(valid), .o_ready(u_ready), .i_inst(inst),
      .i_pc(pc_in), .i_flush(flush), .i_ready(rdy), .o_valid(u_valid), .i_wb_en(wb_en),
      .i_wb_rd_num(wb_rd), .i_wb_val(wb_val), .i_ex_load(ex_load), .i_ex_rd_num(ex_rd),
      .rs_1(u_rs_1), .rs_2(u_rs_2), .rd_num(u_rd), .opcode(u_op), .func_3(u_f3),
      .func_7(u_f7), .imm(u_imm), .pc(u_pc), .b_taken(u_taken), .b_pc(u_bpc));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] r1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {im, r1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] r2, input logic [4:0] r1,
                                         input logic [4:0] rd, input logic [6:0] op);
      return {7'b0, r2, r1, 3'b000, rd, op};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] r2,
                                         input logic [4:0] r1, input logic [2:0] f3);
      return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] mread(input logic [4:0] r);
      if (r == 0) return 32'h0;
      if (wb_en && wb_rd == r) return wb_val;
      return m_regs[r];
   endfunction

   // Immediates from arithmetic on the signed word rather than bit-field wiring where possible.
   function automatic logic [31:0] mimm(input logic [31:0] w);
      logic signed [31:0] s;
      s = w;
      case (w[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: return 32'(s >>> 20);
         7'b0100011: return (32'(s >>> 20) & ~32'h1F) | 32'(w[11:7]);
         7'b1100011: return (32'(s >>> 19) & ~32'hFFF) | {20'h0, w[7], w[30:25], w[11:8], 1'b0};
         7'b0110111, 7'b0010111: return w & 32'hFFFF_F000;
         7'b1101111: return (32'(s >>> 11) & ~32'hF_FFFF) | {12'h0, w[19:12], w[20], w[30:21], 1'b0};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic mtaken(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] b);
      int signed sa, sb;
      sa = a;
      sb = b;
      if (op == 7'b1101111 || op == 7'b1100111) return 1'b1;
      if (op != 7'b1100011) return 1'b0;
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return sa < sb;
         3'd5: return !(sa < sb);
         3'd6: return a < b;
         3'd7: return !(a < b);
         default: return 1'b0;
      endcase
   endfunction

   task automatic mreset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_pc = 0;
      m_rd = 0; m_op = 0; m_f7 = 0; m_f3 = 0;
   endtask

   task automatic idle();
      valid = 0; flush = 0; rdy = 1; wb_en = 0; ex_load = 0;
      wb_rd = 0; ex_rd = 0; wb_val = 0;
   endtask

   // Called just after a falling edge with inputs applied; returns at the next falling edge.
   task automatic step();
      logic [31:0] a, b, im, tgt;
      logic [6:0]  op;
      logic        u1, u2, hz, exp_rdy, acc, tk;
      op  = inst[6:0];
      a   = mread(inst[19:15]);
      b   = mread(inst[24:20]);
      im  = mimm(inst);
      u1  = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
      u2  = (op == 7'b1100011 || op == 7'b0100011 || op == 7'b0110011);
      hz  = ex_load && ex_rd != 0 && ((u1 && inst[19:15] == ex_rd) || (u2 && inst[24:20] == ex_rd));
      exp_rdy = (!m_valid || rdy) && !hz;
      acc = valid && exp_rdy && !flush;
      tk  = acc && mtaken(op, inst[14:12], a, b);
      tgt = !tk ? 32'h0 : (op == 7'b1100111) ? ((a + im) & ~32'h1) : pc_in + im;
      #1;
      obs_ready = o_ready;
      obs_tk    = b_taken;
      obs_bpc   = b_pc;
      check("o_ready", {31'b0, o_ready}, {31'b0, exp_rdy});
      check("b_taken", {31'b0, b_taken}, {31'b0, tk});
      check("b_pc", b_pc, tgt);
      @(posedge i_clk);
      if (flush) m_valid = 0;
      else if (acc) begin
         m_valid = 1; m_rs1 = a; m_rs2 = b; m_imm = im; m_pc = pc_in;
         m_rd = inst[11:7]; m_op = op; m_f3 = inst[14:12]; m_f7 = inst[31:25];
      end else if (rdy) m_valid = 0;
      if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_val;
      #1;
      check("o_valid", {31'b0, o_valid}, {31'b0, m_valid});
      check("rs_1", rs_1, m_rs1);
      check("rs_2", rs_2, m_rs2);
      check("imm", imm, m_imm);
      check("pc", pc, m_pc);
      check("rd_num", {27'b0, rd_num}, {27'b0, m_rd});
      check("opcode", {25'b0, opcode}, {25'b0, m_op});
      check("func_3", {29'b0, func_3}, {29'b0, m_f3});
      check("func_7", {25'b0, func_7}, {25'b0, m_f7});
      @(negedge i_clk);
   endtask

   task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
      idle();
      wb_en = 1; wb_rd = r; wb_val = v; inst = 32'h0000_0013;
      step();
      idle();
   endtask

   initial begin
      logic [6:0] ops [11];
      logic [31:0] held_pc;
      ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
              7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011, 7'b0001111};
      i_rst = 0;
      idle();
      inst = 32'h0; pc_in = 32'h0;
      mreset();
      repeat (2) @(negedge i_clk);
      check("rst o_valid", {31'b0, o_valid}, 32'h0);
      check("rst rs_1", rs_1, 32'h0);
      check("rst imm", imm, 32'h0);
      check("rst pc", pc, 32'h0);
      i_rst = 1;
      @(negedge i_clk);

      // Same-cycle write-back bypass.
      idle();
      valid = 1; inst = 32'hFFF2_8313; pc_in = 32'h10;
      wb_en = 1; wb_rd = 5; wb_val = 32'h1234;
      step();
      check("bypass rs_1", rs_1, 32'h1234);
      check("bypass imm", imm, 32'hFFFF_FFFF);

      wb_write(5'd0, 32'hDEAD);
      valid = 1; inst = enc_i(12'h0, 5'd0, 3'b000, 5'd8, 7'b0010011);
      step();
      check("x0 reads 0", rs_1, 32'h0);

      // Load-use stall, then release.
      idle();
      valid = 1; inst = enc_r(5'd1, 5'd5, 5'd7, 7'b0110011); ex_load = 1; ex_rd = 5;
      step();
      check("load-use o_ready", {31'b0, obs_ready}, 32'h0);
      check("load-use bubble", {31'b0, o_valid}, 32'h0);
      ex_load = 0;
      step();
      check("load-use released", {31'b0, o_valid}, 32'h1);
      check("load-use rs_1", rs_1, 32'h1234);

      // Signed vs unsigned branch.
      wb_write(5'd1, 32'hFFFF_FFFF);
      wb_write(5'd2, 32'h1);
      valid = 1; pc_in = 32'h100; inst = enc_b(13'd8, 5'd2, 5'd1, 3'b100);
      step();
      check("blt taken", {31'b0, obs_tk}, 32'h1);
      check("blt target", obs_bpc, 32'h108);
      inst = enc_b(13'd8, 5'd2, 5'd1, 3'b110);
      step();
      check("bltu not taken", {31'b0, obs_tk}, 32'h0);

      // Backpressure hold, then flush.
      idle();
      valid = 1; pc_in = 32'h200; inst = enc_i(12'h7, 5'd1, 3'b000, 5'd9, 7'b0010011);
      step();
      held_pc = 32'h200;
      rdy = 0; pc_in = 32'h300; inst = enc_i(12'h9, 5'd2, 3'b000, 5'd10, 7'b0010011);
      step();
      check("stall o_ready", {31'b0, obs_ready}, 32'h0);
      check("stall pc held", pc, held_pc);
      rdy = 1; flush = 1; inst = 32'h0080_006F;
      step();
      check("flush b_taken", {31'b0, obs_tk}, 32'h0);
      check("flush o_valid", {31'b0, o_valid}, 32'h0);

      // JALR target alignment.
      wb_write(5'd3, 32'h201);
      valid = 1; pc_in = 32'h40; inst = enc_i(12'd4, 5'd3, 3'b000, 5'd1, 7'b1100111);
      step();
      check("jalr target", obs_bpc, 32'h204);

      // Register beyond REG_COUNT=16.
      wb_write(5'd20, 32'hABCD);
      valid = 1; inst = enc_i(12'h0, 5'd20, 3'b000, 5'd1, 7'b0010011);
      step();
      check("rc16 x20 reads 0", u_rs_1, 32'h0);
      check("rc32 x20 reads back", rs_1, 32'hABCD);

      // Reset mid-transfer.
      valid = 1; inst = enc_i(12'h5, 5'd5, 3'b000, 5'd6, 7'b0010011); pc_in = 32'h500;
      step();
      check("pre-reset o_valid", {31'b0, o_valid}, 32'h1);
      #2 i_rst = 0;
      #1;
      mreset();
      check("async rst o_valid", {31'b0, o_valid}, 32'h0);
      check("async rst rs_1", rs_1, 32'h0);
      check("async rst imm", imm, 32'h0);
      @(negedge i_clk);
      i_rst = 1;
      idle();
      valid = 1; inst = enc_i(12'h0, 5'd5, 3'b000, 5'd6, 7'b0010011);
      step();
      check("x5 after reset", rs_1, 32'h0);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         valid   = ($urandom_range(0, 3) != 0);
         flush   = ($urandom_range(0, 9) == 0);
         rdy     = ($urandom_range(0, 3) != 0);
         wb_en   = ($urandom_range(0, 1) == 1);
         wb_rd   = 5'($urandom_range(0, 7));
         wb_val  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         ex_load = ($urandom_range(0, 3) == 0);
         ex_rd   = 5'($urandom_range(0, 7));
         pc_in   = $urandom & 32'hFFFF_FFFC;
         inst    = $urandom;
         inst[6:0]   = ops[$urandom_range(0, 10)];
         inst[11:7]  = 5'($urandom_range(0, 7));
         inst[19:15] = 5'($urandom_range(0, 7));
         inst[24:20] = 5'($urandom_range(0, 7));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
